hwpf_nl_issue_ctrl: RTL and testbench
=====================================

Name: hwpf_nl_issue_ctrl

Overview:
Sequencing controller for the next-line prefetcher's hwpf_stack.
- Converts L1 demand-miss notifications into next-line candidates and pushes them onto the stack.
- Pops candidates when request credits are available and expands each into DEGREE sequential line requests.
- Issues requests to the cache refill port over a valid/ready handshake, capped by an outstanding-request limit.

Parameters:
ADDR_W, 40, address width in bits; matches drac_pkg::addr_t.
LINE_BYTES, 64, cache line size in bytes; power of two.
DEGREE, 2, lines issued per popped candidate; range 1..8.
MAX_OUTSTANDING, 4, maximum accepted-but-uncompleted prefetches; range 1..15.
PAGE_BYTES, 4096, prefetch page boundary; power of two, at least LINE_BYTES.

Ports:
clk_i  in  1  clock; all logic on rising edge.
rst_i  in  1  asynchronous, active-high reset.
enable_i  in  1  prefetcher enable.
flush_i  in  1  abort all sequencing; forwarded to the stack.
miss_valid_i  in  1  L1 demand miss this cycle.
miss_addr_i  in  ADDR_W  demand miss byte address.
stk_push_o  out  1  push to hwpf_stack.
stk_val_o  out  ADDR_W  value pushed.
stk_pop_o  out  1  pop from hwpf_stack.
stk_lock_o  out  1  lock hwpf_stack.
stk_flush_o  out  1  flush hwpf_stack.
stk_valid_i  in  1  stack top valid.
stk_req_i  in  ADDR_W  stack top value.
pf_valid_o  out  1  prefetch request valid.
pf_addr_o  out  ADDR_W  prefetch line address; line-aligned.
pf_ready_i  in  1  cache accepts the request.
pf_done_i  in  1  one outstanding prefetch has completed.
busy_o  out  1  high when state is not IDLE or outstanding count is nonzero.

Behaviour:
- Reset (asynchronous, rst_i=1):
  - State IDLE; base, idx and outstanding registers cleared.
  - All outputs 0, except stk_lock_o = ~enable_i and stk_flush_o = flush_i (both combinational).
- Push path (combinational):
  - stk_push_o = miss_valid_i & enable_i & ~flush_i.
  - stk_val_o = line-aligned(miss_addr_i) + LINE_BYTES, truncated to ADDR_W; wrap at the top of the address space is discarded by truncation.
- FSM states: IDLE, ISSUE, WAIT_CREDIT.
- IDLE:
  - If enable_i & stk_valid_i & (outstanding < MAX_OUTSTANDING) & ~flush_i: assert stk_pop_o for exactly one cycle, latch base <= stk_req_i, idx <= 0, go to ISSUE.
  - A same-cycle push from the push path is legal; the stack returns its pre-push top.
- ISSUE:
  - pf_valid_o = 1; pf_addr_o = base + idx*LINE_BYTES.
  - pf_addr_o stays stable until accepted or until flush_i is asserted.
  - On pf_ready_i: outstanding increments, idx increments.
    - If idx == DEGREE-1, or the next address crosses a PAGE_BYTES boundary (drop the remainder): go to IDLE.
    - Else if outstanding+1 == MAX_OUTSTANDING: go to WAIT_CREDIT.
  - If outstanding == MAX_OUTSTANDING on entry, pf_valid_o stays 0 and the FSM goes to WAIT_CREDIT.
- WAIT_CREDIT:
  - pf_valid_o = 0; return to ISSUE the cycle after outstanding < MAX_OUTSTANDING.
- Outstanding counter:
  - +1 on accepted request; -1 on pf_done_i.
  - Both in the same cycle: no change.
  - pf_done_i at 0 is ignored (saturating).
- enable_i deassert: finish the current beat handshake if pf_valid_o is high, then go to IDLE; no new pops.
- flush_i:
  - Next state is IDLE; pf_valid_o is 0 in the flush cycle (combinational gate); stk_pop_o and stk_push_o are 0.
  - Outstanding is not cleared, because completions still return.
- Simultaneous flush_i and pf_ready_i: the request is treated as not accepted.

Optional Feature:
HWPF_NL_DEDUP_EN
- Defined:
  - A last_push register (ADDR_W plus a valid bit, cleared by reset and flush) suppresses stk_push_o when the computed stk_val_o equals last_push.
  - Updated on every performed push.
- Undefined: every qualifying miss is pushed; no extra state.

Test Plan:
- Reset, enable_i=1, miss_valid_i=1, miss_addr_i=40'hCAFE0010 -> stk_push_o=1, stk_val_o=40'hCAFE0040 in the same cycle.
- Stack top 40'hCAFE0040 valid, pf_ready_i=1 -> stk_pop_o pulse, then pf_addr_o 40'hCAFE0040 then 40'hCAFE0080 on consecutive cycles; return to IDLE; outstanding=2.
- MAX_OUTSTANDING=1, DEGREE=2, pf_done_i=0 -> one request issued, WAIT_CREDIT with pf_valid_o=0; pf_done_i pulse -> 40'hCAFE0080 issued next-next cycle.
- Top 40'hCAFE0FC0 -> only 40'hCAFE0FC0 issued (page cross at 40'hCAFE1000 dropped).
- flush_i during ISSUE with pf_ready_i=0 -> pf_valid_o=0 same cycle, IDLE next, stk_flush_o=1, outstanding unchanged.
- With HWPF_NL_DEDUP_EN, two misses at 40'hCAFE0010 and 40'hCAFE0020 -> single push of 40'hCAFE0040; without the macro -> two pushes.

Source files
------------

// File: rtl/hwpf_nl_issue_ctrl.sv
// Next-line prefetch issue controller for hwpf_stack.
// Turns L1 demand misses into next-line candidates pushed onto the stack. It
// pops candidates when credits allow and expands each one into DEGREE
// sequential line requests. The expansion stops early at a page boundary.
// Optional feature macro: HWPF_NL_DEDUP_EN suppresses back-to-back duplicate pushes.
module hwpf_nl_issue_ctrl #(
  parameter int unsigned ADDR_W          = 40,
  parameter int unsigned LINE_BYTES      = 64,
  parameter int unsigned DEGREE          = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned PAGE_BYTES      = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic              miss_valid_i,
  input  logic [ADDR_W-1:0] miss_addr_i,
  output logic              stk_push_o,
  output logic [ADDR_W-1:0] stk_val_o,
  output logic              stk_pop_o,
  output logic              stk_lock_o,
  output logic              stk_flush_o,
  input  logic              stk_valid_i,
  input  logic [ADDR_W-1:0] stk_req_i,
  output logic              pf_valid_o,
  output logic [ADDR_W-1:0] pf_addr_o,
  input  logic              pf_ready_i,
  input  logic              pf_done_i,
  output logic              busy_o
);

  localparam int unsigned       LineShift = $clog2(LINE_BYTES);
  localparam logic [ADDR_W-1:0] LineOff   = ADDR_W'(LINE_BYTES - 1);
  localparam logic [ADDR_W-1:0] LineStep  = ADDR_W'(LINE_BYTES);
  localparam logic [ADDR_W-1:0] PageOff   = ADDR_W'(PAGE_BYTES - 1);
  localparam logic [3:0]        IdxLast   = 4'(DEGREE - 1);
  localparam logic [3:0]        MaxOut    = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitCredit} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        outst_q, outst_d;

  logic [ADDR_W-1:0] push_val;
  logic              push_raw;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] next_addr;
  logic              credit_ok;
  logic              accept;
  logic              page_end;
  logic              done_dec;

  // Push path: next line after the missing line; wrap at the top is dropped.
  assign push_val    = (miss_addr_i & ~LineOff) + LineStep;
  assign push_raw    = miss_valid_i & enable_i & ~flush_i;
  assign stk_val_o   = push_val;
  assign stk_lock_o  = ~enable_i;
  assign stk_flush_o = flush_i;

`ifdef HWPF_NL_DEDUP_EN
  logic [ADDR_W-1:0] last_push_q;
  logic              last_push_vld_q;

  assign stk_push_o = push_raw & ~(last_push_vld_q & (last_push_q == push_val));

  // Remember the most recent pushed candidate so repeats are filtered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_push_q     <= '0;
      last_push_vld_q <= 1'b0;
    end else if (flush_i) begin
      last_push_vld_q <= 1'b0;
    end else if (stk_push_o) begin
      last_push_q     <= push_val;
      last_push_vld_q <= 1'b1;
    end
  end
`else
  assign stk_push_o = push_raw;
`endif

  // Issue datapath.
  assign cur_addr   = base_q + (ADDR_W'(idx_q) << LineShift);
  assign next_addr  = cur_addr + LineStep;
  assign page_end   = (next_addr & PageOff) == '0;
  assign credit_ok  = outst_q < MaxOut;
  // Flush gates the valid, so a flush-cycle ready can never count as accepted.
  assign pf_valid_o = (state_q == StIssue) & credit_ok & ~flush_i;
  assign pf_addr_o  = cur_addr;
  assign accept     = pf_valid_o & pf_ready_i;
  assign done_dec   = pf_done_i & (outst_q != '0);
  assign busy_o     = (state_q != StIdle) | (outst_q != '0);

  // Next-state, pop and candidate expansion.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    idx_d     = idx_q;
    stk_pop_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_i && stk_valid_i && credit_ok && !flush_i) begin
          stk_pop_o = 1'b1;
          base_d    = stk_req_i & ~LineOff;
          idx_d     = '0;
          state_d   = StIssue;
        end
      end
      StIssue: begin
        if (!credit_ok) begin
          state_d = enable_i ? StWaitCredit : StIdle;
        end else if (accept) begin
          idx_d = idx_q + 4'd1;
          // Disable lets the in-flight beat complete, then drops the rest.
          if ((idx_q == IdxLast) || page_end || !enable_i) begin
            state_d = StIdle;
          end else if (outst_q + 4'd1 == MaxOut) begin
            state_d = StWaitCredit;
          end
        end
      end
      StWaitCredit: begin
        if (!enable_i) begin
          state_d = StIdle;
        end else if (credit_ok) begin
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush_i) begin
      state_d = StIdle;
    end
  end

  // Outstanding count: accepted requests in, completions out, floor at zero.
  always_comb begin
    outst_d = outst_q;
    if (accept && !done_dec) begin
      outst_d = outst_q + 4'd1;
    end else if (!accept && done_dec) begin
      outst_d = outst_q - 4'd1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      base_q  <= '0;
      idx_q   <= '0;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      idx_q   <= idx_d;
      outst_q <= outst_d;
    end
  end

endmodule

// File: tb/tb_hwpf_nl_issue_ctrl.sv
// Scoreboard bench for hwpf_nl_issue_ctrl. The bench plays the role of
// hwpf_stack with a LIFO queue. Each pop expands the popped candidate into the
// expected line list, and the monitor pops that list on each accepted request.
module tb_hwpf_nl_issue_ctrl;

  localparam int unsigned AW   = 40;
  localparam int unsigned DEG  = 2;
  localparam int unsigned MAXO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable, flush, miss_valid;
  logic [AW-1:0] miss_addr;
  logic          stk_push, stk_pop, stk_lock, stk_flush;
  logic [AW-1:0] stk_val;
  logic          stk_valid;
  logic [AW-1:0] stk_req;
  logic          pf_valid, pf_ready, pf_done, busy;
  logic [AW-1:0] pf_addr;

  always #5 clk = ~clk;

  hwpf_nl_issue_ctrl #(
    .ADDR_W         (AW),
    .LINE_BYTES     (64),
    .DEGREE         (DEG),
    .MAX_OUTSTANDING(MAXO),
    .PAGE_BYTES     (4096)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .enable_i    (enable),
    .flush_i     (flush),
    .miss_valid_i(miss_valid),
    .miss_addr_i (miss_addr),
    .stk_push_o  (stk_push),
    .stk_val_o   (stk_val),
    .stk_pop_o   (stk_pop),
    .stk_lock_o  (stk_lock),
    .stk_flush_o (stk_flush),
    .stk_valid_i (stk_valid),
    .stk_req_i   (stk_req),
    .pf_valid_o  (pf_valid),
    .pf_addr_o   (pf_addr),
    .pf_ready_i  (pf_ready),
    .pf_done_i   (pf_done),
    .busy_o      (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [AW-1:0] stk_q[$];  // front is the stack top
  logic [AW-1:0] exp_q[$];  // expected line addresses of the current candidate
  int unsigned   out_m = 0; // model of accepted-but-uncompleted requests

`ifdef HWPF_NL_DEDUP_EN
  logic [AW-1:0] lp     = '0;
  logic          lp_vld = 1'b0;
`endif

  // Values sampled by step() for directed checks.
  logic          s_pop, s_valid, s_busy, s_push;
  logic [AW-1:0] s_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  // Lines to request for one candidate: DEGREE lines, stopping at the page end.
  task automatic expand(input logic [AW-1:0] base);
    logic [AW-1:0] a;
    for (int k = 0; k < int'(DEG); k++) begin
      a = base + AW'(k * 64);
      if (a[AW-1:12] != base[AW-1:12]) break;
      exp_q.push_back(a);
    end
  endtask

  // One clock: check the push side mid-cycle, then update the stack model.
  task automatic step();
    logic          exp_push;
    logic [AW-1:0] exp_val;
    logic [AW-1:0] top;
    @(negedge clk);
    exp_val  = {miss_addr[AW-1:6], 6'd0} + AW'(64);
    exp_push = miss_valid && enable && !flush;
`ifdef HWPF_NL_DEDUP_EN
    if (exp_push && lp_vld && (lp == exp_val)) exp_push = 1'b0;
`endif
    chk("stk_push", stk_push, exp_push);
    if (exp_push) chk("stk_val", stk_val, exp_val);
    chk("stk_flush", stk_flush, flush);
    chk("stk_lock", stk_lock, !enable);
    s_pop   = stk_pop;
    s_push  = stk_push;
    s_valid = pf_valid;
    s_addr  = pf_addr;
    s_busy  = busy;
    if (s_pop) chk("pop_legal", stk_q.size() != 0 && exp_q.size() == 0 && out_m < MAXO
                   && !flush && enable, 1);
    @(posedge clk);
    #1;
    if (flush) begin
      stk_q.delete();
`ifdef HWPF_NL_DEDUP_EN
      lp_vld = 1'b0;
`endif
    end else begin
      // The stack hands out its pre-push top on a same-cycle pop and push.
      if (s_pop && stk_q.size() != 0) begin
        top = stk_q.pop_front();
        expand(top);
      end
      if (exp_push) begin
        stk_q.push_front(exp_val);
`ifdef HWPF_NL_DEDUP_EN
        lp     = exp_val;
        lp_vld = 1'b1;
`endif
      end
    end
    stk_valid = stk_q.size() != 0;
    stk_req   = (stk_q.size() != 0) ? stk_q[0] : '0;
  endtask

  // Monitor: compare every accepted request against the scoreboard.
  always @(negedge clk) begin
    logic [AW-1:0] e;
    int unsigned   acc, dec;
    if (!rst) begin
      if (pf_valid) chk("pf_credit", out_m < MAXO, 1);
      if (flush) chk("pf_valid_flush", pf_valid, 0);
      chk("busy", busy, (out_m != 0) || (exp_q.size() != 0));
      acc = (pf_valid && pf_ready) ? 1 : 0;
      if (acc != 0) begin
        chk("pf_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("pf_addr", pf_addr, e);
        end
      end
      if (flush) exp_q.delete();
      dec = (pf_done && out_m != 0) ? 1 : 0;
      out_m <= out_m + acc - dec;
    end
  end

  initial begin
    int unsigned npush;
    rst = 1'b1; enable = 1'b0; flush = 1'b1; miss_valid = 1'b1;
    miss_addr = 40'h00CAFE0010; pf_ready = 1'b1; pf_done = 1'b0;
    stk_valid = 1'b1; stk_req = 40'h00CAFE0040;
    repeat (2) @(negedge clk);
    chk("reset_pf_valid", pf_valid, 0);
    chk("reset_pop", stk_pop, 0);
    chk("reset_push", stk_push, 0);
    chk("reset_busy", busy, 0);
    chk("reset_lock", stk_lock, 1);
    chk("reset_flush", stk_flush, 1);
    @(posedge clk); #1;
    rst = 1'b0; enable = 1'b1; flush = 1'b0; miss_valid = 1'b0;
    stk_valid = 1'b0; stk_req = '0; pf_ready = 1'b1;

    // Miss -> push, pop, two consecutive lines, then drain completions.
    miss_valid = 1'b1; miss_addr = 40'h00CAFE0010;
    step();
    chk("d2_push", s_push, 1);
    miss_valid = 1'b0;
    step(); chk("d2_pop", s_pop, 1);
    step(); chk("d2_valid0", s_valid, 1); chk("d2_addr0", s_addr, 40'h00CAFE0040);
    step(); chk("d2_valid1", s_valid, 1); chk("d2_addr1", s_addr, 40'h00CAFE0080);
    step(); chk("d2_idle", s_valid, 0); chk("d2_busy2", s_busy, 1);
    pf_done = 1'b1;
    step(); step();
    pf_done = 1'b0;
    step(); chk("d2_drained", s_busy, 0);

    // Candidate at the last line of a page issues exactly one request.
    miss_valid = 1'b1; miss_addr = 40'h00CAFE0F80;
    step(); miss_valid = 1'b0;
    step(); chk("d3_pop", s_pop, 1);
    step(); chk("d3_valid", s_valid, 1); chk("d3_addr", s_addr, 40'h00CAFE0FC0);
    step(); chk("d3_no_cross0", s_valid, 0);
    step(); chk("d3_no_cross1", s_valid, 0);
    pf_done = 1'b1; step(); pf_done = 1'b0;

    // Flush while a request is waiting for ready.
    pf_ready = 1'b0;
    miss_valid = 1'b1; miss_addr = 40'h00CAFE0100;
    step(); miss_valid = 1'b0;
    step(); chk("d4_pop", s_pop, 1);
    step(); chk("d4_valid", s_valid, 1); chk("d4_addr", s_addr, 40'h00CAFE0140);
    flush = 1'b1;
    step(); chk("d4_flush_gate", s_valid, 0);
    flush = 1'b0;
    step(); chk("d4_idle", s_valid, 0); chk("d4_busy", s_busy, 0);
    step(); chk("d4_stay", s_valid, 0);
    pf_ready = 1'b1;

    // Two misses in the same line.
    npush = 0;
    miss_valid = 1'b1; miss_addr = 40'h00CAFE0010;
    step(); npush += s_push;
    miss_addr = 40'h00CAFE0020;
    step(); npush += s_push;
    miss_valid = 1'b0;
`ifdef HWPF_NL_DEDUP_EN
    chk("dedup_push_count", npush, 1);
`else
    chk("dedup_push_count", npush, 2);
`endif

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      miss_valid = ($urandom % 4) == 0;
      if (($urandom % 4) != 0) begin
        if (($urandom % 64) == 0) miss_addr = 40'hFFFFFFFFC0 + AW'($urandom % 64);
        else miss_addr = 40'h00CAFE0000 + AW'($urandom_range(0, 65535));
      end
      flush    = ($urandom % 50) == 0;
      pf_ready = ($urandom % 4) != 0;
      pf_done  = ($urandom % 3) == 0;
      step();
    end

    // Drain everything still queued.
    miss_valid = 1'b0; flush = 1'b0; pf_ready = 1'b1; pf_done = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      if (stk_q.size() == 0 && exp_q.size() == 0 && out_m == 0) break;
      step();
    end
    chk("drain_complete", stk_q.size() == 0 && exp_q.size() == 0 && out_m == 0, 1);
    pf_done = 1'b0;
    repeat (3) step();
    chk("final_idle", s_busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
